// File: rtl/add_jmp_pkg.sv
// Shared definitions for the add/jump core: opcodes, FSM states, the
// instruction-word width formula and field-slice helpers.
// Instruction word layout, MSB first: {op[1:0], rs, rd, imm}.
package add_jmp_pkg;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_JNZ = 2'b11;

    // Helper functions work on a generously wide container so that a single
    // definition serves every legal parameterisation of the core.
    localparam int MAX_INST_W  = 256;
    localparam int MAX_FIELD_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10
    } state_t;

    function automatic int inst_width(input int data_w, input int rs_w);
        return 2 + 2 * rs_w + data_w;
    endfunction

    function automatic logic [1:0] inst_op(input logic [MAX_INST_W-1:0] word,
                                           input int data_w, input int rs_w);
        return 2'(word >> (data_w + 2 * rs_w));
    endfunction

    function automatic logic [MAX_FIELD_W-1:0] inst_rs(input logic [MAX_INST_W-1:0] word,
                                                        input int data_w, input int rs_w);
        return MAX_FIELD_W'(word >> (data_w + rs_w));
    endfunction

    function automatic logic [MAX_FIELD_W-1:0] inst_rd(input logic [MAX_INST_W-1:0] word,
                                                        input int data_w);
        return MAX_FIELD_W'(word >> data_w);
    endfunction

    function automatic logic [MAX_FIELD_W-1:0] inst_imm(input logic [MAX_INST_W-1:0] word);
        return MAX_FIELD_W'(word);
    endfunction

endpackage

// File: rtl/add_jmp_regfile.sv
// General register file: two asynchronous read ports, one synchronous write
// port, synchronous active-high reset clearing every register.
module add_jmp_regfile
    import add_jmp_pkg::*;
#(
    parameter  int NREGS  = 4,
    parameter  int DATA_W = 16,
    localparam int RS_W   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [RS_W-1:0]         waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [RS_W-1:0]         raddr_a,
    output logic [DATA_W-1:0]       rdata_a,
    input  logic [RS_W-1:0]         raddr_b,
    output logic [DATA_W-1:0]       rdata_b,
    output logic [NREGS*DATA_W-1:0] regs_flat
);

    logic [DATA_W-1:0] regs_r [NREGS];

    // Register storage: reset clears all entries, otherwise one write per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_r[raddr_a];
    assign rdata_b = regs_r[raddr_b];

    // Flatten the array for observation; r0 sits in the least significant slice.
    always_comb begin
        regs_flat = {(NREGS*DATA_W){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_r[i];
        end
    end

endmodule

// File: rtl/add_jmp_core.sv
// Add/jump instruction-set processor core: program memory, program counter,
// fetch/execute FSM and the register-file instance.
// Optional feature macro: ADD_JMP_CORE_HALT_EN adds the 'halted' output; a
// JMP or taken JNZ that targets its own address then freezes stepping until
// rst or the next rising edge of prog.
module add_jmp_core
    import add_jmp_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int NREGS      = 4,
    parameter  int PMEM_DEPTH = 16,
    localparam int RS_W       = $clog2(NREGS),
    localparam int PC_W       = $clog2(PMEM_DEPTH),
    localparam int INST_W     = inst_width(DATA_W, RS_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prog,
    input  logic                    prog_we,
    input  logic [1:0]              prog_op,
    input  logic [RS_W-1:0]         prog_rs,
    input  logic [RS_W-1:0]         prog_rd,
    input  logic [DATA_W-1:0]       prog_imm,
    input  logic                    advance,
    output logic                    busy,
    output logic [PC_W-1:0]         pc,
    output logic [PC_W-1:0]         wr_ptr,
    output logic [DATA_W-1:0]       o_b,
    output logic [NREGS*DATA_W-1:0] o_regs,
    output logic [INST_W-1:0]       inst_dbg
`ifdef ADD_JMP_CORE_HALT_EN
    ,
    output logic                    halted
`endif
);

    state_t              state_r;
    state_t              state_nx_s;
    logic                busy_r;
    logic                prog_d_r;
    logic                prog_rise_s;
    logic                mem_we_s;
    logic [INST_W-1:0]   mem_r [PMEM_DEPTH];
    logic [INST_W-1:0]   fetch_r;
    logic [INST_W-1:0]   inst_in_s;
    logic [PC_W-1:0]     pc_r;
    logic [PC_W-1:0]     wr_ptr_r;
    logic [PC_W-1:0]     wr_addr_s;
    logic [PC_W-1:0]     pc_inc_s;
    logic [PC_W-1:0]     pc_nx_s;
    logic [PC_W-1:0]     jmp_tgt_s;
    logic [1:0]          op_s;
    logic [RS_W-1:0]     rs_s;
    logic [RS_W-1:0]     rd_s;
    logic [DATA_W-1:0]   imm_s;
    logic [DATA_W-1:0]   rs_val_s;
    logic [DATA_W-1:0]   br_val_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic                wr_en_s;
    logic                exec_s;
    logic                halt_block_s;
    logic [DATA_W-1:0]   o_b_r;
    logic [INST_W-1:0]   inst_dbg_r;

    assign prog_rise_s = prog & ~prog_d_r;
    assign mem_we_s    = prog & prog_we & ~rst;
    // A write in the same cycle as program-mode entry lands at address 0.
    assign wr_addr_s   = prog_rise_s ? {PC_W{1'b0}} : wr_ptr_r;
    assign inst_in_s   = {prog_op, prog_rs, prog_rd, prog_imm};
    assign exec_s      = (state_r == ST_EXEC);
    assign pc_inc_s    = pc_r + PC_W'(1);

    // Decode the word captured during FETCH.
    assign op_s      = inst_op(MAX_INST_W'(fetch_r), DATA_W, RS_W);
    assign rs_s      = RS_W'(inst_rs(MAX_INST_W'(fetch_r), DATA_W, RS_W));
    assign rd_s      = RS_W'(inst_rd(MAX_INST_W'(fetch_r), DATA_W));
    assign imm_s     = DATA_W'(inst_imm(MAX_INST_W'(fetch_r)));
    assign jmp_tgt_s = imm_s[PC_W-1:0];

    add_jmp_regfile #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (exec_s & wr_en_s),
        .waddr     (rd_s),
        .wdata     (wr_data_s),
        .raddr_a   (rs_s),
        .rdata_a   (rs_val_s),
        .raddr_b   (rs_s),
        .rdata_b   (br_val_s),
        .regs_flat (o_regs)
    );

    // Program memory: written only in program mode, read synchronously in FETCH.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_addr_s] <= inst_in_s;
        end
        if (state_r == ST_FETCH) begin
            fetch_r <= mem_r[pc_r];
        end
    end

`ifdef ADD_JMP_CORE_HALT_EN
    logic halted_r;
    logic halt_hit_s;

    // A jump that lands on its own address is the halt condition.
    assign halt_hit_s = exec_s && (jmp_tgt_s == pc_r) &&
                        ((op_s == OP_JMP) || ((op_s == OP_JNZ) && (br_val_s != {DATA_W{1'b0}})));

    // Halt flag: set by a self-jump, cleared by reset or program-mode entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else if (prog_rise_s) begin
            halted_r <= 1'b0;
        end else if (halt_hit_s) begin
            halted_r <= 1'b1;
        end
    end

    assign halt_block_s = halted_r;
    assign halted       = halted_r;
`else
    assign halt_block_s = 1'b0;
`endif

    // Execute-stage result selection: register write data and next pc.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = {DATA_W{1'b0}};
        pc_nx_s   = pc_inc_s;
        case (op_s)
            OP_LDI: begin
                wr_en_s   = 1'b1;
                wr_data_s = imm_s;
            end
            OP_ADD: begin
                wr_en_s   = 1'b1;
                wr_data_s = imm_s + rs_val_s;
            end
            OP_JMP: begin
                pc_nx_s = jmp_tgt_s;
            end
            OP_JNZ: begin
                if (br_val_s != {DATA_W{1'b0}}) begin
                    pc_nx_s = jmp_tgt_s;
                end else begin
                    pc_nx_s = pc_inc_s;
                end
            end
            default: begin
                pc_nx_s = pc_inc_s;
            end
        endcase
    end

    // Next-state logic; a step starts only from IDLE in run mode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (advance && !prog && !halt_block_s) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: state_nx_s = ST_EXEC;
            ST_EXEC:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // State register, pointers and architectural outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            prog_d_r   <= 1'b0;
            pc_r       <= {PC_W{1'b0}};
            wr_ptr_r   <= {PC_W{1'b0}};
            o_b_r      <= {DATA_W{1'b0}};
            inst_dbg_r <= {INST_W{1'b0}};
        end else begin
            state_r  <= state_nx_s;
            busy_r   <= (state_nx_s != ST_IDLE);
            prog_d_r <= prog;
            if (prog_rise_s) begin
                pc_r <= {PC_W{1'b0}};
            end else if (exec_s) begin
                pc_r <= pc_nx_s;
            end
            if (mem_we_s) begin
                wr_ptr_r <= wr_addr_s + PC_W'(1);
            end else if (prog_rise_s) begin
                wr_ptr_r <= {PC_W{1'b0}};
            end
            if (exec_s) begin
                o_b_r      <= rs_val_s;
                inst_dbg_r <= fetch_r;
            end
        end
    end

    assign busy     = busy_r;
    assign pc       = pc_r;
    assign wr_ptr   = wr_ptr_r;
    assign o_b      = o_b_r;
    assign inst_dbg = inst_dbg_r;

endmodule

// File: doc/add_jmp_core.md
Name: add_jmp_core

Overview:
- Parametrised next-generation add/jump instruction-set processor with a fully synchronous datapath.
- Contains an internal program memory, a program counter, a register file and an ALU.
- Programming and stepping are controlled by sampled strobes rather than by using switches as clocks.
- Generalised from the fixed 16-bit / 4-register / 16-word machine: widths are parametric, the ISA gains load-immediate and conditional jump, and each step runs through an explicit fetch/execute FSM.

Parameters:
- DATA_W, 16, register, immediate and ALU width.
- NREGS, 4, number of general registers; power of two, minimum 2; RS_W = log2(NREGS).
- PMEM_DEPTH, 16, program memory words; power of two; PC_W = log2(PMEM_DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- prog  in  1  level; 1 = program mode, 0 = run mode.
- prog_we  in  1  strobe; in program mode, writes one instruction at wr_ptr.
- prog_op  in  2  opcode of the instruction being written.
- prog_rs  in  RS_W  source register field.
- prog_rd  in  RS_W  destination register field.
- prog_imm  in  DATA_W  immediate field.
- advance  in  1  strobe; in run mode, executes one instruction.
- busy  out  1  high while the FSM is in FETCH or EXEC.
- pc  out  PC_W  current program counter.
- wr_ptr  out  PC_W  next program write address.
- o_b  out  DATA_W  r[rs] of the last executed instruction.
- o_regs  out  NREGS*DATA_W  flattened register file; r0 occupies the LSBs.
- inst_dbg  out  INST_W  last fetched instruction word.

Behaviour:
- Clocking: single clk domain. rst is synchronous and active-high.
- Reset values: pc=0, wr_ptr=0, all registers 0, o_b=0, inst_dbg=0, busy=0, FSM=IDLE. Memory contents are not reset.
- Instruction word, INST_W = 2+2*RS_W+DATA_W: {op, rs, rd, imm}, MSB first.
- Opcodes:
  - LDI=00: rd <= imm.
  - ADD=01: rd <= imm + r[rs], mod 2^DATA_W, carry dropped.
  - JMP=10: pc <= imm[PC_W-1:0].
  - JNZ=11: pc <= imm[PC_W-1:0] if r[rs]!=0, else pc+1.
- Non-jump instructions: pc <= pc+1, wrapping from PMEM_DEPTH-1 to 0.
- Program mode (prog=1):
  - prog_we writes the assembled word at wr_ptr in that cycle, then wr_ptr increments with wrap.
  - advance is ignored.
  - Rising edge of prog: wr_ptr <= 0, pc <= 0; registers are kept.
- Run-mode FSM, states IDLE, FETCH, EXEC:
  - IDLE + advance + !prog -> FETCH.
  - FETCH: synchronous memory read of mem[pc] -> EXEC.
  - EXEC: latch inst_dbg; update register / o_b / pc -> IDLE.
  - Latency: advance sampled at edge N; results visible after edge N+2. Minimum 3 cycles between accepted steps.
- advance while busy is dropped, not queued.
- prog_we while prog=0 is ignored.
- prog asserted mid-step: the FSM completes EXEC normally, then holds in IDLE.
- rst mid-step: the step is aborted with no register or pc write; outputs go to reset values next edge.
- ADD with rd==rs: uses the old r[rs].
- o_b is updated for every opcode, including JMP.

Optional Feature:
- Macro: ADD_JMP_CORE_HALT_EN.
- When defined:
  - Adds output halted (1 bit, reset 0).
  - EXEC of a JMP whose target == pc, or a taken JNZ whose target == pc, sets halted=1.
  - While halted, advance is ignored.
  - halted is cleared by rst or by the rising edge of prog.
- When undefined:
  - No halted port.
  - A self-jump simply re-executes on every advance.

Decomposition:
- Package add_jmp_pkg holds:
  - opcode localparams OP_LDI, OP_ADD, OP_JMP, OP_JNZ;
  - FSM state enum ST_IDLE, ST_FETCH, ST_EXEC;
  - the INST_W formula and field-slice helper functions.
- One natural sub-module: add_jmp_regfile.
  - Parameters NREGS and DATA_W.
  - Two async read ports, one sync write port, synchronous reset.
- The PC, memory and FSM stay in the core.

Test Plan:
- Reset: rst during EXEC -> next cycle pc=0, o_regs all 0, busy=0.
- Program {LDI r1 5; ADD r2 imm=3 rs=r1; JMP 0}, then 3 advance pulses:
  - r1=5, r2=8, pc=0;
  - busy high for exactly 2 cycles per step.
- Counting loop {LDI r0 3; ADD r0 imm=FFFF rs=r0; JNZ imm=1 rs=r0}:
  - 7 steps -> r0=0;
  - final JNZ falls through to pc=3.
- Wrap cases:
  - 17 prog_we writes -> word 16 overwrites address 0, wr_ptr=1.
  - ADD FFFF+r=2 -> 0001.
- Dropped / ignored strobes:
  - advance on a cycle while busy=1 -> ignored; exactly one step executes.
  - prog_we while prog=0 -> memory unchanged.
- HALT_EN:
  - JMP to its own address -> halted=1; further advance leaves pc unchanged.
  - Toggle prog -> halted=0.
